cacheline_adaptor: RTL and testbench

- Responder end of the cache's pmem interface.
- Accepts 256-bit line reads and writes from the instruction or data cache, and performs each as a 4-beat, 64-bit burst on the physical-memory bus.
- Returns the assembled line with a one-cycle line-side response.
- Sits between the cache pmem ports and main memory (or the arbiter).

---
 rtl/cacheline_adaptor.sv | 113 +++++++++++
 tb/tb_cacheline_adaptor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cache line reads/writes to 4-beat, 64-bit physical-memory bursts.
// Optional macro ADAPTER_TIMEOUT_EN adds a stalled-memory timeout with sticky err_o.
module cacheline_adaptor #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read_i,
  input  logic         line_write_i,
  input  logic [31:0]  line_addr_i,
  input  logic [255:0] line_wdata_i,
  output logic [255:0] line_rdata_o,
  output logic         line_resp_o,
  output logic         burst_read_o,
  output logic         burst_write_o,
  output logic [31:0]  burst_addr_o,
  output logic [63:0]  burst_wdata_o,
  input  logic [63:0]  burst_rdata_i,
  input  logic         burst_resp_i,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t         state, state_next;
  logic [1:0]     cnt;
  logic [31:0]    addr_q;
  logic [255:0]   wline_q;
  logic           busy;
  logic           beat;
  logic           timeout;

  assign busy = (state == READ) || (state == WRITE);
  assign beat = busy && burst_resp_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (line_write_i)     state_next = WRITE;
        else if (line_read_i) state_next = READ;
      end
      READ, WRITE: begin
        if ((beat && cnt == 2'd3) || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the line buffers are reset too, because the fill line is a visible output that must read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      addr_q       <= '0;
      wline_q      <= '0;
      line_rdata_o <= '0;
    end else begin
      if (state == IDLE && (line_write_i || line_read_i)) begin
        addr_q <= {line_addr_i[31:5], 5'b0};
        if (line_write_i) wline_q <= line_wdata_i;
      end
      if (beat) begin
        cnt <= cnt + 2'd1;
        if (state == READ) line_rdata_o[{cnt, 6'd0} +: 64] <= burst_rdata_i;
      end else if (timeout) begin
        cnt <= '0;
      end
    end
  end

  assign burst_read_o  = (state == READ);
  assign burst_write_o = (state == WRITE);
  assign burst_addr_o  = addr_q;
  assign burst_wdata_o = (state == WRITE) ? wline_q[{cnt, 6'd0} +: 64] : '0;
  assign line_resp_o   = (state == DONE);

`ifdef ADAPTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the stalled cycle that would bring the idle count to TIMEOUT_CYCLES.
  assign timeout = busy && !burst_resp_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!busy || burst_resp_i || timeout) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a memory responder model checks write beats
// and supplies read beats; expected fill lines are queued at issue and popped at line_resp_o.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_read_i = 1'b0;
  logic         line_write_i = 1'b0;
  logic [31:0]  line_addr_i = '0;
  logic [255:0] line_wdata_i = '0;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [31:0]  burst_addr_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i = '0;
  logic         burst_resp_i = 1'b0;
  logic         err_o;

  cacheline_adaptor #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .line_read_i   (line_read_i),
    .line_write_i  (line_write_i),
    .line_addr_i   (line_addr_i),
    .line_wdata_i  (line_wdata_i),
    .line_rdata_o  (line_rdata_o),
    .line_resp_o   (line_resp_o),
    .burst_read_o  (burst_read_o),
    .burst_write_o (burst_write_o),
    .burst_addr_o  (burst_addr_o),
    .burst_wdata_o (burst_wdata_o),
    .burst_rdata_i (burst_rdata_i),
    .burst_resp_i  (burst_resp_i),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model controls and scoreboard queues
  logic [255:0] mem_words = '0;
  int           mem_lat = 0;
  bit           mem_gap = 0;
  bit           mem_silent = 0;
  bit           force_idle_resp = 0;
  logic [31:0]  exp_addr = '0;
  logic [63:0]  wbeat_q[$];
  logic [255:0] line_q[$];
  int           rd_hi = 0;
  int           wait_cnt = 0;
  int           beat_i = 0;
  bit           toggle = 0;

  always @(negedge clk) begin
    if (burst_read_o) rd_hi++;
    if (rst || !(burst_read_o || burst_write_o)) begin
      burst_resp_i = force_idle_resp;
      wait_cnt = 0;
      beat_i   = 0;
      toggle   = 0;
    end else if (mem_silent) begin
      burst_resp_i = 1'b0;
    end else if (wait_cnt < mem_lat) begin
      wait_cnt++;
      burst_resp_i = 1'b0;
    end else if (mem_gap && toggle) begin
      toggle = 0;
      burst_resp_i = 1'b0;
      if (burst_write_o && wbeat_q.size() != 0) check("wdata_hold", burst_wdata_o, wbeat_q[0]);
    end else begin
      burst_resp_i = 1'b1;
      toggle = 1;
      check("burst_addr", burst_addr_o, exp_addr);
      if (burst_read_o) begin
        burst_rdata_i = mem_words[beat_i*64 +: 64];
      end else begin
        check("wbeat_avail", wbeat_q.size() != 0, 1);
        if (wbeat_q.size() != 0) check("wbeat", burst_wdata_o, wbeat_q.pop_front());
      end
      beat_i++;
    end
  end

  task automatic wait_resp(input string tag, input int max_cyc, output bit seen);
    seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (line_resp_o) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_resp_seen"}, seen, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int lat,
                         input string tag);
    bit seen;
    logic [255:0] exp_line;
    mem_words = line;
    mem_lat   = lat;
    mem_gap   = 0;
    exp_addr  = {addr[31:5], 5'b0};
    line_q.push_back(line);
    rd_hi = 0;
    line_addr_i = addr;
    line_read_i = 1'b1;
    wait_resp(tag, 100, seen);
    exp_line = line_q.pop_front();
    if (seen) check({tag, "_rdata"}, line_rdata_o, exp_line);
    line_read_i = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, line_resp_o, 0);
  endtask

  task automatic push_wbeats(input logic [255:0] line);
    for (int i = 0; i < 4; i++) wbeat_q.push_back(line[i*64 +: 64]);
  endtask

  logic [255:0] wline, rline;
  bit           seen;
  bit           resp_hit;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ctrl", {burst_read_o, burst_write_o, line_resp_o, err_o}, 4'b0);
    check("rst_addr", burst_addr_o, 0);
    check("rst_rdata", line_rdata_o, 0);
    check("rst_wdata", burst_wdata_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Read with three idle memory cycles before a contiguous burst
    rline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, rline, 3, "rd1");
    check("rd1_read_cycles", rd_hi, 7);

    // Write with memory accepting every other cycle; wdata changes after capture
    wline = {64'hDEAD_3333_3333_BEEF, 64'hDEAD_2222_2222_BEEF,
             64'hDEAD_1111_1111_BEEF, 64'hDEAD_0000_0000_BEEF};
    push_wbeats(wline);
    mem_lat = 0;
    mem_gap = 1;
    exp_addr = 32'h0000_0040;
    line_addr_i  = 32'h0000_0040;
    line_wdata_i = wline;
    line_write_i = 1'b1;
    @(negedge clk);
    line_wdata_i = ~wline;
    line_addr_i  = 32'hFFFF_FFFF;
    wait_resp("wr1", 100, seen);
    check("wr1_beats_left", wbeat_q.size(), 0);
    line_write_i = 1'b0;
    @(negedge clk);
    check("wr1_pulse", line_resp_o, 0);
    mem_gap = 0;

    // Write and read together: write burst first, then read of the same line
    wline = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
             64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    rline = {64'h0B3B_0B3B_0B3B_0B3B, 64'h0B2B_0B2B_0B2B_0B2B,
             64'h0B1B_0B1B_0B1B_0B1B, 64'h0B0B_0B0B_0B0B_0B0B};
    push_wbeats(wline);
    mem_words = rline;
    mem_lat = 1;
    exp_addr = 32'h0000_0080;
    line_q.push_back(rline);
    rd_hi = 0;
    line_addr_i  = 32'h0000_009C;
    line_wdata_i = wline;
    line_write_i = 1'b1;
    line_read_i  = 1'b1;
    wait_resp("dual_w", 100, seen);
    check("dual_w_beats_left", wbeat_q.size(), 0);
    check("dual_w_no_read", rd_hi, 0);
    line_write_i = 1'b0;
    wait_resp("dual_r", 100, seen);
    rline = line_q.pop_front();
    if (seen) check("dual_r_rdata", line_rdata_o, rline);
    check("dual_read_cycles", rd_hi, 5);
    line_read_i = 1'b0;
    @(negedge clk);
    check("dual_pulse", line_resp_o, 0);

    // Reset after beat 2 of a read discards the partial line
    mem_words = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    mem_lat = 0;
    exp_addr = 32'h0000_2000;
    line_addr_i = 32'h0000_2000;
    line_read_i = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    line_read_i = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", {burst_read_o, burst_write_o, line_resp_o, err_o}, 4'b0);
    check("midrst_addr", burst_addr_o, 0);
    check("midrst_rdata", line_rdata_o, 0);
    rst = 1'b0;
    @(negedge clk);
    rline = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
             64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    do_read(32'h0000_2010, rline, 2, "rd_after_rst");

    // Stray beat-valid pulses while idle are ignored
    force_idle_resp = 1'b1;
    resp_hit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (line_resp_o || burst_read_o || burst_write_o) resp_hit = 1;
    end
    force_idle_resp = 1'b0;
    @(negedge clk);
    check("idle_resp_ignored", resp_hit, 0);
    rline = {64'h6666_6666_0000_0004, 64'h6666_6666_0000_0003,
             64'h6666_6666_0000_0002, 64'h6666_6666_0000_0001};
    do_read(32'h0000_3FE0, rline, 0, "rd_after_idle");

    // Memory never responds
    mem_silent = 1'b1;
    rd_hi = 0;
    exp_addr = 32'h0000_4000;
    line_addr_i = 32'h0000_4000;
    line_read_i = 1'b1;
`ifdef ADAPTER_TIMEOUT_EN
    wait_resp("tmo", 20, seen);
    check("tmo_err_set", err_o, 1);
    check("tmo_read_cycles", rd_hi, 8);
    line_read_i = 1'b0;
    repeat (4) @(negedge clk);
    check("tmo_err_sticky", err_o, 1);
    check("tmo_idle", {burst_read_o, line_resp_o}, 2'b0);
`else
    resp_hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (line_resp_o) resp_hit = 1;
    end
    check("stall_no_resp", resp_hit, 0);
    check("stall_err", err_o, 0);
    check("stall_read_held", burst_read_o, 1);
    line_read_i = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_silent = 1'b0;
    check("final_err_clear", err_o, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
